// File: rtl/bsub_serial_nb_pkg.sv
// ============================================================================
// Module      : bsub_serial_nb_pkg
// Description : Shared definitions for the bit-serial subtractor: FSM state
//               encoding and the operand-width legality check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bsub_serial_nb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A serial datapath needs at least two bits to be meaningful
    function automatic bit width_ok(input int w);
        return (w >= 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsub_serial_nb_fs_1b.sv
// ============================================================================
// Module      : fs_1b
// Description : Combinational 1-bit full subtractor (in0 - in1 - borrow_in).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_1b (
    input  logic in0,
    input  logic in1,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = in0 ^ in1 ^ borrow_in;
    // Borrow when the subtrahend bit wins outright, or the bits tie and a
    // borrow is already pending
    assign borrow_out = (~in0 & in1) | (~(in0 ^ in1) & borrow_in);

endmodule

`default_nettype wire

// File: rtl/bsub_serial_nb.sv
// ============================================================================
// Module      : bsub_serial_nb
// Description : Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock,
//               with valid/ready handshakes on operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsub_serial_nb
    import bsub_serial_nb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("bsub_serial_nb: WIDTH must be >= 2");
    end

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    // Holds the WIDTH-1 already-computed bits; the final bit joins on the last cycle
    logic [WIDTH-2:0]   r_r_sr;
    logic               r_borrow;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;

    logic               w_d;
    logic               w_bw_next;
    logic [WIDTH-1:0]   w_r_cat;
    logic               w_accept;
    logic               w_last;

    fs_1b u_fs (
        .in0        (r_a_sr[0]),
        .in1        (r_b_sr[0]),
        .borrow_in  (r_borrow),
        .diff       (w_d),
        .borrow_out (w_bw_next)
    );

    assign w_r_cat  = {w_d, r_r_sr};
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_count == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register alone
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Serial datapath: operand load, per-bit shift, and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_r_sr       <= '0;
            r_borrow     <= 1'b0;
            r_count      <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= minuend;
            r_b_sr   <= subtrahend;
            r_borrow <= 1'b0;
            r_count  <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_r_sr   <= w_r_cat[WIDTH-1:1];
            r_borrow <= w_bw_next;
            if (w_last) begin
                r_diff       <= w_r_cat;
                r_borrow_out <= w_bw_next;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

`default_nettype wire
